// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment capture path: glyph table, FSM states, sample payload.
package seg7_pkg;

    localparam int unsigned SEG7_DIGITS_MAX = 8;
    localparam int unsigned SEG7_IDX_W      = 3;

    // Segment patterns, a = bit0 ... g = bit6, active-high
    localparam logic [6:0] SEG7_GLYPH_0 = 7'h3F;
    localparam logic [6:0] SEG7_GLYPH_1 = 7'h06;
    localparam logic [6:0] SEG7_GLYPH_2 = 7'h5B;
    localparam logic [6:0] SEG7_GLYPH_3 = 7'h4F;
    localparam logic [6:0] SEG7_GLYPH_4 = 7'h66;
    localparam logic [6:0] SEG7_GLYPH_5 = 7'h6D;
    localparam logic [6:0] SEG7_GLYPH_6 = 7'h7D;
    localparam logic [6:0] SEG7_GLYPH_7 = 7'h07;
    localparam logic [6:0] SEG7_GLYPH_8 = 7'h7F;
    localparam logic [6:0] SEG7_GLYPH_9 = 7'h6F;
    localparam logic [6:0] SEG7_GLYPH_A = 7'h77;
    localparam logic [6:0] SEG7_GLYPH_B = 7'h7C;
    localparam logic [6:0] SEG7_GLYPH_C = 7'h39;
    localparam logic [6:0] SEG7_GLYPH_D = 7'h5E;
    localparam logic [6:0] SEG7_GLYPH_E = 7'h79;
    localparam logic [6:0] SEG7_GLYPH_F = 7'h71;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRACK  = 2'd1,
        COMMIT = 2'd2,
        HOLD   = 2'd3
    } seg7_state_e;

    typedef struct packed {
        logic       dp;
        logic [6:0] seg;
    } seg7_glyph_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational segment-pattern to hex-value decoder; legal=0 for any non-glyph pattern.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic       legal,
    output logic [3:0] value
);

    always_comb begin
        legal = 1'b1;
        value = 4'h0;
        case (seg)
            SEG7_GLYPH_0: value = 4'h0;
            SEG7_GLYPH_1: value = 4'h1;
            SEG7_GLYPH_2: value = 4'h2;
            SEG7_GLYPH_3: value = 4'h3;
            SEG7_GLYPH_4: value = 4'h4;
            SEG7_GLYPH_5: value = 4'h5;
            SEG7_GLYPH_6: value = 4'h6;
            SEG7_GLYPH_7: value = 4'h7;
            SEG7_GLYPH_8: value = 4'h8;
            SEG7_GLYPH_9: value = 4'h9;
            SEG7_GLYPH_A: value = 4'hA;
            SEG7_GLYPH_B: value = 4'hB;
            SEG7_GLYPH_C: value = 4'hC;
            SEG7_GLYPH_D: value = 4'hD;
            SEG7_GLYPH_E: value = 4'hE;
            SEG7_GLYPH_F: value = 4'hF;
            default:      legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_capture_decoder.sv
// Samples a multiplexed 7-segment bus, waits for a stable pattern, decodes it into per-digit slots.
// Define SEG7_CAP_ACTIVE_LOW_EN for common-anode (active-low) segment, dp and digit-enable lines.
module seg7_capture_decoder
    import seg7_pkg::*;
#(
    parameter int unsigned DIGITS        = 4,
    parameter int unsigned STABLE_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg_in,
    input  logic                  dp_in,
    input  logic [DIGITS-1:0]     dig_en,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]     dp_out,
    output logic [DIGITS-1:0]     valid,
    output logic                  upd,
    output logic [SEG7_IDX_W-1:0] upd_idx,
    output logic                  sel_err
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);

    seg7_glyph_t       glyph_raw, glyph_q, glyph_prev;
    logic [DIGITS-1:0] en_raw, en_q, en_prev;

`ifdef SEG7_CAP_ACTIVE_LOW_EN
    assign glyph_raw = ~{dp_in, seg_in};
    assign en_raw    = ~dig_en;
`else
    assign glyph_raw = {dp_in, seg_in};
    assign en_raw    = dig_en;
`endif

    // Input register plus one-deep history for change detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            glyph_q    <= '0;
            glyph_prev <= '0;
            en_q       <= '0;
            en_prev    <= '0;
        end else begin
            glyph_q    <= glyph_raw;
            glyph_prev <= glyph_q;
            en_q       <= en_raw;
            en_prev    <= en_q;
        end
    end

    logic word_chg, en_any, en_onehot, legal;
    logic [3:0] value;
    logic [SEG7_IDX_W-1:0] idx_c;

    assign word_chg  = {en_q, glyph_q} != {en_prev, glyph_prev};
    assign en_any    = |en_q;
    assign en_onehot = en_any && ((en_q & (en_q - DIGITS'(1))) == '0);

    always_comb begin
        idx_c = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (en_q[i]) idx_c = SEG7_IDX_W'(i);
        end
    end

    seg7_pattern_decode u_decode (
        .seg   (glyph_q.seg),
        .legal (legal),
        .value (value)
    );

    seg7_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              commit, sel_set;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A word change always restarts tracking, from any non-idle state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        sel_set = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (en_any) begin
                    state_d = TRACK;
                    cnt_d   = CNT_W'(1);
                end
            end
            TRACK: begin
                if (word_chg) begin
                    state_d = en_any ? TRACK : IDLE;
                    cnt_d   = en_any ? CNT_W'(1) : '0;
                end else if (cnt_q >= CNT_W'(STABLE_CYCLES)) begin
                    if (en_onehot) begin
                        state_d = COMMIT;
                        commit  = 1'b1;
                    end else begin
                        state_d = HOLD;
                        sel_set = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            COMMIT, HOLD: begin
                if (word_chg) begin
                    state_d = en_any ? TRACK : IDLE;
                    cnt_d   = en_any ? CNT_W'(1) : '0;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Per-digit register file; only the enabled slot is written on commit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bcd_out <= '0;
            dp_out  <= '0;
            valid   <= '0;
            upd     <= 1'b0;
            upd_idx <= '0;
            sel_err <= 1'b0;
        end else begin
            upd     <= commit;
            sel_err <= sel_err | sel_set;
            if (commit) upd_idx <= idx_c;
            for (int i = 0; i < int'(DIGITS); i++) begin
                if (commit && en_q[i]) begin
                    dp_out[i] <= glyph_q.dp;
                    valid[i]  <= legal;
                    if (legal) bcd_out[4*i +: 4] <= value;
                end
            end
        end
    end

endmodule
